// File: rtl/n64_controller_responder.sv
// n64_controller_responder
// Device side of the N64 single-wire controller protocol. It decodes the
// console's command byte from the open-drain line. For 0x00/0xFF it replies
// with ID_WORD (24 bits). For 0x01 it replies with the buttons word latched
// when the command was accepted (32 bits). Any other valid byte is reported
// on cmd_valid and gets no reply.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   buttons        live button/stick status, latched at command accept
//   dataController open-drain protocol line (driven 0 or released)
//   cmd_valid      one-cycle pulse on a valid command byte
//   cmd_byte       last valid command byte
//   busy           high while a frame or reply is in progress
//   resp_done      one-cycle pulse when the reply stop bit completes
//   rx_error       one-cycle pulse on a malformed or timed-out command
//
// Optional build macro N64_RESP_GLITCH_FILTER_EN adds a 3-sample filter on
// the synchronized line. The filter ignores low glitches of 1 or 2 cycles.
//
// state   | meaning
// IDLE    | line released, waiting for a falling edge
// RX_LOW  | measuring a console low pulse
// RX_HIGH | console bit high time, waiting for the next falling edge
// GAP     | released turnaround before the reply
// TX_LOW  | driving the low part of a reply bit
// TX_HIGH | releasing for the high part of a reply bit
// TX_STOP | driving the reply stop bit
module n64_controller_responder #(
    parameter int          CLKS_PER_US = 50,
    parameter int          RESP_GAP_US = 2,
    parameter logic [23:0] ID_WORD     = 24'h050002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] buttons,
    inout  wire         dataController,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        busy,
    output logic        resp_done,
    output logic        rx_error
);

    localparam int TMAX = 5 * CLKS_PER_US;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_LOW_TO   = TW'(TMAX);
    localparam logic [TW-1:0] T_HIGH_TO  = TW'(4 * CLKS_PER_US);
    localparam logic [TW-1:0] T_DECIDE   = TW'(2 * CLKS_PER_US);
    localparam logic [TW-1:0] T_1US_M1   = TW'(CLKS_PER_US - 1);
    localparam logic [TW-1:0] T_3US_M1   = TW'(3 * CLKS_PER_US - 1);
    localparam logic [TW-1:0] T_STOP_M1  = TW'(2 * CLKS_PER_US - 1);
    localparam logic [TW-1:0] T_GAP_M1   = TW'(RESP_GAP_US * CLKS_PER_US - 1);

    typedef enum logic [2:0] {
        IDLE, RX_LOW, RX_HIGH, GAP, TX_LOW, TX_HIGH, TX_STOP
    } state_t;

    state_t        state, stateNext;
    logic [TW-1:0] timer, timerNext;
    logic [5:0]    bitCnt, bitCntNext;
    logic [7:0]    shiftReg, shiftRegNext;
    logic [31:0]   txData, txDataNext;
    logic [4:0]    txIdx, txIdxNext;
    logic          hasReply, hasReplyNext;
    logic [7:0]    cmdByteNext;
    logic          cmdValidNext, respDoneNext, rxErrorNext;

    logic lineSync1, lineSync2, lineLevel, linePrev;
    logic fallEdge, riseEdge, lowIsOne, txBit;

    // Drive low only while sending. Otherwise release the line to the pull-up.
    assign dataController = (state == TX_LOW || state == TX_STOP) ? 1'b0 : 1'bz;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            lineSync1 <= 1'b1;
            lineSync2 <= 1'b1;
        end else begin
            lineSync1 <= dataController;
            lineSync2 <= lineSync1;
        end
    end

`ifdef N64_RESP_GLITCH_FILTER_EN
    // The level follows the line only after three equal consecutive samples:
    // the live sample plus two history samples.
    logic [1:0] hist;
    logic       filtHeld;
    always_comb begin
        lineLevel = filtHeld;
        if (lineSync2 == hist[0] && lineSync2 == hist[1])
            lineLevel = lineSync2;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hist     <= 2'b11;
            filtHeld <= 1'b1;
        end else begin
            hist     <= {hist[0], lineSync2};
            filtHeld <= lineLevel;
        end
    end
`else
    assign lineLevel = lineSync2;
`endif

    assign fallEdge = linePrev & ~lineLevel;
    assign riseEdge = ~linePrev & lineLevel;
    assign lowIsOne = (timer < T_DECIDE);
    assign txBit    = txData[txIdx];

    always_comb begin
        stateNext    = state;
        timerNext    = timer;
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        txDataNext   = txData;
        txIdxNext    = txIdx;
        hasReplyNext = hasReply;
        cmdByteNext  = cmd_byte;
        cmdValidNext = 1'b0;
        respDoneNext = 1'b0;
        rxErrorNext  = 1'b0;
        case (state)
            IDLE: begin
                if (fallEdge) begin
                    stateNext    = RX_LOW;
                    timerNext    = TW'(1);
                    bitCntNext   = '0;
                    shiftRegNext = '0;
                end
            end
            RX_LOW: begin
                if (riseEdge) begin
                    if (bitCnt == 6'd8) begin
                        timerNext = '0;
                        if (lowIsOne) begin
                            stateNext    = GAP;
                            cmdValidNext = 1'b1;
                            cmdByteNext  = shiftReg;
                            hasReplyNext = 1'b1;
                            if (shiftReg == 8'h00 || shiftReg == 8'hFF) begin
                                txDataNext = {8'h00, ID_WORD};
                                txIdxNext  = 5'd23;
                            end else if (shiftReg == 8'h01) begin
                                txDataNext = buttons;
                                txIdxNext  = 5'd31;
                            end else begin
                                hasReplyNext = 1'b0;
                            end
                        end else begin
                            stateNext   = IDLE;
                            rxErrorNext = 1'b1;
                        end
                    end else begin
                        stateNext    = RX_HIGH;
                        timerNext    = TW'(1);
                        shiftRegNext = {shiftReg[6:0], lowIsOne};
                        bitCntNext   = bitCnt + 6'd1;
                    end
                end else if (timer == T_LOW_TO) begin
                    stateNext   = IDLE;
                    timerNext   = '0;
                    rxErrorNext = 1'b1;
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
            RX_HIGH: begin
                if (fallEdge) begin
                    stateNext = RX_LOW;
                    timerNext = TW'(1);
                end else if (timer == T_HIGH_TO) begin
                    stateNext   = IDLE;
                    timerNext   = '0;
                    rxErrorNext = 1'b1;
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == T_GAP_M1) begin
                    timerNext = '0;
                    stateNext = hasReply ? TX_LOW : IDLE;
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
            TX_LOW: begin
                if (timer == (txBit ? T_1US_M1 : T_3US_M1)) begin
                    timerNext = '0;
                    stateNext = TX_HIGH;
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
            TX_HIGH: begin
                if (timer == (txBit ? T_3US_M1 : T_1US_M1)) begin
                    timerNext = '0;
                    if (txIdx == 5'd0) begin
                        stateNext = TX_STOP;
                    end else begin
                        txIdxNext = txIdx - 5'd1;
                        stateNext = TX_LOW;
                    end
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
            TX_STOP: begin
                if (timer == T_STOP_M1) begin
                    timerNext    = '0;
                    stateNext    = IDLE;
                    respDoneNext = 1'b1;
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                timerNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            txData    <= '0;
            txIdx     <= '0;
            hasReply  <= 1'b0;
            linePrev  <= 1'b1;
            cmd_byte  <= '0;
            cmd_valid <= 1'b0;
            resp_done <= 1'b0;
            rx_error  <= 1'b0;
        end else begin
            state     <= stateNext;
            timer     <= timerNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftRegNext;
            txData    <= txDataNext;
            txIdx     <= txIdxNext;
            hasReply  <= hasReplyNext;
            linePrev  <= lineLevel;
            cmd_byte  <= cmdByteNext;
            cmd_valid <= cmdValidNext;
            resp_done <= respDoneNext;
            rx_error  <= rxErrorNext;
        end
    end

endmodule

// File: tb/tb_n64_controller_responder.sv
// tb_n64_controller_responder
// Directed bench for n64_controller_responder with CLKS_PER_US=4. The bench
// plays the console side of the line through a pull-up. It decodes the reply
// from low and high durations sampled on the falling clock edge.
module tb_n64_controller_responder;

    localparam int CPU = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] buttons;
    logic        conDrive;
    wire         dataLine;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        busy;
    logic        resp_done;
    logic        rx_error;

    pullup (dataLine);
    assign dataLine = conDrive ? 1'b0 : 1'bz;

    n64_controller_responder #(
        .CLKS_PER_US(CPU),
        .RESP_GAP_US(2),
        .ID_WORD(24'h050002)
    ) dut (
        .clk(clk),
        .reset(reset),
        .buttons(buttons),
        .dataController(dataLine),
        .cmd_valid(cmd_valid),
        .cmd_byte(cmd_byte),
        .busy(busy),
        .resp_done(resp_done),
        .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cvCnt = 0, rdCnt = 0, errCnt = 0, dutLowCnt = 0, busyCnt = 0;
    int gapCnt = 0, gapMeas = -1;
    bit gapArm = 1'b0;

    // Event counters, and the released time from cmd_valid to the first
    // low driven by the DUT.
    always @(negedge clk) begin
        if (cmd_valid) cvCnt++;
        if (resp_done) rdCnt++;
        if (rx_error)  errCnt++;
        if (busy)      busyCnt++;
        if (dataLine === 1'b0 && !conDrive) dutLowCnt++;
        if (cmd_valid) begin
            gapArm = 1'b1;
            gapCnt = 1;
        end else if (gapArm) begin
            if (dataLine === 1'b0 && !conDrive) begin
                gapMeas = gapCnt;
                gapArm  = 1'b0;
            end else if (gapCnt > 100) begin
                gapArm = 1'b0;
            end else begin
                gapCnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sendLow(input int n);
        conDrive = 1'b1;
        repeat (n) step();
        conDrive = 1'b0;
    endtask

    task automatic sendBit(input logic b);
        sendLow(b ? CPU : 3 * CPU);
        repeat (b ? 3 * CPU : CPU) step();
    endtask

    task automatic sendCmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) sendBit(c[i]);
        sendLow(CPU);  // console stop bit, then line left released
    endtask

    // Called at a negedge. Waits for low, counts low samples, then high samples.
    task automatic measure(output int lowC, output int highC, output bit to);
        int w;
        w = 0; lowC = 0; highC = 0; to = 1'b0;
        while (dataLine !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) to = 1'b1;
        while (dataLine === 1'b0 && lowC < 100) begin
            lowC++;
            @(negedge clk);
        end
        while (dataLine !== 1'b0 && highC < 40) begin
            highC++;
            @(negedge clk);
        end
    endtask

    task automatic recvReply(input int n, output logic [31:0] data, output int badT,
                             output int stopLow);
        int lc, hc;
        bit to;
        data = '0;
        badT = 0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            measure(lc, hc, to);
            if (to || !((lc == CPU && hc == 3 * CPU) || (lc == 3 * CPU && hc == CPU)))
                badT++;
            data = {data[30:0], (lc == CPU)};
        end
        measure(lc, hc, to);
        stopLow = to ? -1 : lc;
    endtask

    initial begin
        logic [31:0] d;
        int bt, sl, cv0, rd0, er0, dl0, bz0, n;
        int lc, hc;
        bit to;

        reset    = 1'b1;
        conDrive = 1'b0;
        buttons  = 32'h0;
        repeat (4) step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_cmd_byte", {24'h0, cmd_byte}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_line", {31'h0, dataLine}, 32'h1);
        chk("reset_pulses", {29'h0, cmd_valid, resp_done, rx_error}, 32'h0);

        // 0x01: reply with the buttons latched at accept. The later change
        // to buttons must not reach the reply.
        cv0 = cvCnt; rd0 = rdCnt; er0 = errCnt; gapMeas = -1;
        buttons = 32'hA5A5_0F0F;
        sendCmd(8'h01);
        repeat (5) step();
        buttons = 32'h0;
        recvReply(32, d, bt, sl);
        chk("t1_cmd_valid_cnt", cvCnt - cv0, 1);
        chk("t1_cmd_byte", {24'h0, cmd_byte}, 32'h01);
        chk("t1_gap", gapMeas, 8);
        chk("t1_data", d, 32'hA5A5_0F0F);
        chk("t1_bit_timing", bt, 0);
        chk("t1_stop_low", sl, 2 * CPU);
        chk("t1_resp_done_cnt", rdCnt - rd0, 1);
        chk("t1_rx_error_cnt", errCnt - er0, 0);
        chk("t1_busy_end", {31'h0, busy}, 32'h0);

        // 0x00 and 0xFF: identity word
        rd0 = rdCnt; gapMeas = -1;
        sendCmd(8'h00);
        recvReply(24, d, bt, sl);
        chk("t2a_cmd_byte", {24'h0, cmd_byte}, 32'h00);
        chk("t2a_gap", gapMeas, 8);
        chk("t2a_data", d, 32'h0005_0002);
        chk("t2a_bit_timing", bt, 0);
        chk("t2a_stop_low", sl, 2 * CPU);
        sendCmd(8'hFF);
        recvReply(24, d, bt, sl);
        chk("t2b_cmd_byte", {24'h0, cmd_byte}, 32'hFF);
        chk("t2b_data", d, 32'h0005_0002);
        chk("t2b_bit_timing", bt, 0);
        chk("t2b_stop_low", sl, 2 * CPU);
        chk("t2_resp_done_cnt", rdCnt - rd0, 2);

        // unknown command: accepted, no reply
        cv0 = cvCnt; rd0 = rdCnt; dl0 = dutLowCnt;
        sendCmd(8'h42);
        repeat (60) step();
        chk("t3_cmd_valid_cnt", cvCnt - cv0, 1);
        chk("t3_cmd_byte", {24'h0, cmd_byte}, 32'h42);
        chk("t3_never_driven", dutLowCnt - dl0, 0);
        chk("t3_resp_done_cnt", rdCnt - rd0, 0);
        chk("t3_busy_end", {31'h0, busy}, 32'h0);

        // 5 bits then line held high. The expected count is 20 negedges from
        // the release: 2 synchronizer flops, 1 edge detect, 16 high-time clocks,
        // and 1 for the first negedge.
        cv0 = cvCnt; er0 = errCnt;
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
        sendLow(3 * CPU);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_error && n < 60);
        chk("t4_err_latency", n, 20);
        repeat (4) step();
        chk("t4_rx_error_cnt", errCnt - er0, 1);
        chk("t4_cmd_valid_cnt", cvCnt - cv0, 0);
        chk("t4_cmd_byte", {24'h0, cmd_byte}, 32'h42);
        chk("t4_busy_end", {31'h0, busy}, 32'h0);

        // 2-clk glitch in IDLE
        er0 = errCnt; bz0 = busyCnt;
        sendLow(2);
`ifdef N64_RESP_GLITCH_FILTER_EN
        repeat (40) step();
        chk("t6_glitch_busy", busyCnt - bz0, 0);
        chk("t6_glitch_err", errCnt - er0, 0);
`else
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_error && n < 60);
        chk("t6_glitch_err_latency", n, 20);
        repeat (4) step();
        chk("t6_glitch_err", errCnt - er0, 1);
`endif

        // reset during reply bit 10
        rd0 = rdCnt; er0 = errCnt;
        buttons = 32'hFFFF_FFFF;
        sendCmd(8'h01);
        @(negedge clk);
        for (int i = 0; i < 9; i++) measure(lc, hc, to);
        chk("t5_busy_in_reply", {31'h0, busy}, 32'h1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_line_released", {31'h0, dataLine}, 32'h1);
        chk("t5_busy_after_reset", {31'h0, busy}, 32'h0);
        chk("t5_cmd_byte_reset", {24'h0, cmd_byte}, 32'h0);
        repeat (60) step();
        chk("t5_no_resp_done", rdCnt - rd0, 0);
        chk("t5_no_rx_error", errCnt - er0, 0);
        buttons = 32'h1234_8001;
        sendCmd(8'h01);
        repeat (5) step();
        recvReply(32, d, bt, sl);
        chk("t5_retry_data", d, 32'h1234_8001);
        chk("t5_retry_bit_timing", bt, 0);
        chk("t5_retry_stop_low", sl, 2 * CPU);
        chk("t5_retry_resp_done", rdCnt - rd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n64_controller_responder.md
Name: n64_controller_responder

Overview:
Device-side end of the N64 single-wire controller protocol. It emulates a controller on the open-drain data line: it decodes the console's command byte, then replies with the identity word or the 32-bit button status. It is used to loop back and test the console-side poll block in simulation and on the board, and as a controller emulator fed by another input source.

Parameters:
CLKS_PER_US, 50, clock cycles per microsecond; all bit timing derives from it (bench uses 4).
RESP_GAP_US, 2, released-line gap between command stop bit and first reply bit, in µs.
ID_WORD, 24'h050002, reply payload for the identity/reset commands.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
buttons  input  32  live button/stick status; latched at command accept
dataController  inout  1  open-drain protocol line; driven 0 or released (z), never driven 1
cmd_valid  output  1  one-cycle pulse when a valid command byte has been received
cmd_byte  output  8  last valid command byte; held until the next cmd_valid
busy  output  1  high from the first detected low edge until return to IDLE
resp_done  output  1  one-cycle pulse when the reply stop bit completes
rx_error  output  1  one-cycle pulse on a malformed or timed-out command frame

Behaviour:
- Reset, applied on any cycle including mid-frame: state IDLE, line released, cmd_byte=0, all pulses 0, busy=0, counters 0.
- The line input passes through a 2-flop synchronizer. All edge and level decisions use the synchronized value.
- Bit encoding in both directions:
  - '0' = 3 µs low, then 1 µs released.
  - '1' = 1 µs low, then 3 µs released.
  - MSB first.
- RX decode: count clocks of each low pulse.
  - Low count < 2*CLKS_PER_US decodes as '1'; otherwise '0'.
  - Decision is made on the rising edge.
- States: IDLE, RX_LOW, RX_HIGH, GAP, TX_LOW, TX_HIGH, TX_STOP.
- IDLE -> RX_LOW on a synchronized falling edge; busy asserts.
- RX_LOW -> RX_HIGH on a rising edge, which shifts in the decoded bit (6-bit bit counter).
- RX_HIGH -> RX_LOW on the next falling edge.
- Frame is 9 pulses: 8 command bits plus a console stop bit, which must decode '1'.
- On the stop-bit rising edge:
  - If 9 bits were received and the stop bit decodes '1': cmd_valid pulses, cmd_byte updates, buttons are latched, and the state goes to GAP.
  - Otherwise: rx_error pulses and the state goes to IDLE.
- Timeouts return to IDLE with rx_error:
  - low pulse > 5 µs;
  - line high > 4 µs in RX_HIGH before the stop bit.
- Command dispatch:
  - 0x00 or 0xFF: 24-bit ID_WORD.
  - 0x01: 32-bit latched buttons.
  - Any other byte: cmd_valid still pulses; no reply; return to IDLE after GAP.
- GAP: line released for RESP_GAP_US*CLKS_PER_US clocks, then TX_LOW with bit index = payload length − 1.
- TX: TX_LOW drives 0 for the bit's low time and TX_HIGH releases for the high time.
  - Index decrements after each TX_HIGH.
  - After bit 0, go to TX_STOP.
- TX_STOP: drive 0 for 2 µs, release, pulse resp_done, go to IDLE.
- Line input is ignored from GAP through TX_STOP. A collision is not detected.
- The falling edge of a new frame is only recognised in IDLE.
- Timer width is sized for 5*CLKS_PER_US. Counters never wrap: a timer saturates at its timeout value.

Optional Feature:
N64_RESP_GLITCH_FILTER_EN:
- Defined: the synchronized line feeds a 3-sample filter. The filtered level changes only after 3 consecutive equal samples, adding 2 cycles of latency to every edge. Any isolated 1- or 2-cycle low glitch in IDLE is ignored and busy stays 0.
- Undefined: raw synchronized level is used. A 1-cycle low in IDLE starts a frame, which ends in rx_error once the RX_HIGH high-time timeout expires.

Test Plan:
1. CLKS_PER_US=4, buttons=0xA5A5_0F0F, console sends 0x01 + stop -> one cycle of cmd_valid, cmd_byte=0x01. After an 8-clk gap the line shows 32 bits 1010_0101…1111 (a '1' is 4 clk low/12 released, a '0' is 12 low/4 released), then an 8-clk low stop; resp_done pulses once; busy falls.
2. Console sends 0x00 -> reply is exactly 24 bits 0x050002 plus stop. Repeat with 0xFF -> identical reply.
3. Console sends 0x42 -> cmd_valid with cmd_byte=0x42, line never driven, return to IDLE, no resp_done.
4. Console stops after 5 bits and holds the line high -> rx_error 16 clks after the last rise, IDLE, cmd_byte unchanged.
5. reset asserted during reply bit 10 -> next cycle line released, busy=0, no resp_done. A following 0x01 command is answered normally.
6. With N64_RESP_GLITCH_FILTER_EN: a 2-clk low pulse in IDLE -> busy stays 0, no rx_error. Without the macro, the same stimulus -> rx_error after 16 clks.
